// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer: digit width, digit limits,
// run-control state encoding and a digit clamp helper.
package timer_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX_ONES = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_MAX_TENS = 4'd5;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    // Saturate a loaded digit to the largest value that digit may hold.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] v,
                                                       input logic [DIGIT_W-1:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit that wraps 0 -> MAX and reports a borrow.
// Load has priority over decrement; loaded values are clamped to MAX.
module bcd_digit_down
    import timer_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = BCD_MAX_ONES
) (
    input  logic               clock,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               dec,
    output logic [DIGIT_W-1:0] digit,
    output logic               borrow,
    output logic               is_zero
);

    // Digit register: clamped load, else wrap-around decrement.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            digit <= '0;
        end else if (load) begin
            digit <= clamp_digit(load_val, MAX);
        end else if (dec) begin
            digit <= (digit == '0) ? MAX : digit - 1'b1;
        end
    end

    assign is_zero = (digit == '0);
    assign borrow  = dec && is_zero;

endmodule

// File: rtl/bcd_countdown_timer.sv
// mm:ss BCD countdown timer with prescaler, start/stop control, shadowed
// preset with optional auto-reload, expiry pulse and preset validation.
// Command priority within a cycle: clr > load > stop > start > tick.
// Digit index 0 is seconds ones, 1 is seconds tens, 2.. are minute digits.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int MIN_DIGITS = 2,
    parameter int TICK_DIV   = 1
) (
    input  logic                    clock,
    input  logic                    clr,
    input  logic                    load,
    input  logic [3:0]              preset_sec_ones,
    input  logic [3:0]              preset_sec_tens,
    input  logic [4*MIN_DIGITS-1:0] preset_mins,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    reload_mode,
    output logic [3:0]              sec_ones,
    output logic [3:0]              sec_tens,
    output logic [4*MIN_DIGITS-1:0] mins,
    output logic                    running,
    output logic                    zero,
    output logic                    done,
    output logic                    load_err
);

    localparam int NDIG = MIN_DIGITS + 2;
    localparam int CW   = DIGIT_W * NDIG;
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    state_t          state, state_n;
    logic [PW-1:0]   presc;
    logic [CW-1:0]   shadow_q;
    logic [CW-1:0]   preset_all;
    logic [CW-1:0]   preset_clamped;
    logic [CW-1:0]   dig_val;
    logic [CW-1:0]   dig_q;
    logic [NDIG-1:0] dig_dec;
    logic [NDIG-1:0] dig_borrow;
    logic [NDIG-1:0] dig_zero;
    logic            tick;
    logic            dec_en;
    logic            reload;
    logic            expiry;
    logic            underflow;
    logic            preset_bad;

    assign preset_all = {preset_mins, preset_sec_tens, preset_sec_ones};

    for (genvar k = 0; k < NDIG; k++) begin : g_digit
        localparam logic [DIGIT_W-1:0] DMAX = (k == 1) ? BCD_MAX_TENS : BCD_MAX_ONES;

        assign preset_clamped[k*DIGIT_W +: DIGIT_W] =
            clamp_digit(preset_all[k*DIGIT_W +: DIGIT_W], DMAX);

        bcd_digit_down #(.MAX(DMAX)) u_digit (
            .clock    (clock),
            .clr      (clr),
            .load     (load || reload),
            .load_val (dig_val[k*DIGIT_W +: DIGIT_W]),
            .dec      (dig_dec[k]),
            .digit    (dig_q[k*DIGIT_W +: DIGIT_W]),
            .borrow   (dig_borrow[k]),
            .is_zero  (dig_zero[k])
        );
    end

    assign preset_bad = (preset_clamped != preset_all);
    assign dig_val    = load ? preset_all : shadow_q;
    assign dig_dec    = {dig_borrow[NDIG-2:0], dec_en};
    assign zero       = &dig_zero;

    // A tick never fires in a cycle that carries a load or stop command.
    assign tick   = (state == RUNNING) && (presc == PMAX) && !load && !stop;
    assign dec_en = tick && !zero;
    assign reload = tick && zero && reload_mode;
    // Expiry: this decrement moves the count from 00..:01 to all zero.
    assign expiry = dec_en && (dig_q[DIGIT_W-1:0] == 4'd1) && (&dig_zero[NDIG-1:1]);
    // Borrow out of the top digit would mean a wrapped count; treat as a halt.
    assign underflow = dig_borrow[NDIG-1];

    // Run-control state register.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            state <= STOPPED;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; a load leaves the run state untouched.
    always_comb begin
        state_n = state;
        if (!load) begin
            case (state)
                STOPPED: begin
                    if (start && !stop && (!zero || reload_mode)) begin
                        state_n = RUNNING;
                    end
                end
                RUNNING: begin
                    if (stop) begin
                        state_n = STOPPED;
                    end else if ((expiry || zero) && !reload_mode) begin
                        state_n = STOPPED;
                    end else if (underflow) begin
                        state_n = STOPPED;
                    end
                end
                default: state_n = STOPPED;
            endcase
        end
    end

    // Prescaler runs only while RUNNING; idle, load and stop hold it at zero.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            presc <= '0;
        end else if (load || stop || (state != RUNNING)) begin
            presc <= '0;
        end else if (presc == PMAX) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Shadow preset and validation flag, both captured on load.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            shadow_q <= '0;
            load_err <= 1'b0;
        end else if (load) begin
            shadow_q <= preset_clamped;
            load_err <= preset_bad;
        end
    end

    // One-cycle expiry pulse, registered from the expiring tick.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            done <= 1'b0;
        end else begin
            done <= expiry;
        end
    end

    assign running  = (state == RUNNING);
    assign sec_ones = dig_q[3:0];
    assign sec_tens = dig_q[7:4];
    assign mins     = dig_q[CW-1:8];

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer with MIN_DIGITS=2, TICK_DIV=4.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_bcd_countdown_timer;

    localparam int MD = 2;
    localparam int TD = 4;

    logic          clock = 1'b0;
    logic          clr = 1'b1;
    logic          load = 1'b0;
    logic [3:0]    preset_sec_ones = '0;
    logic [3:0]    preset_sec_tens = '0;
    logic [4*MD-1:0] preset_mins = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          reload_mode = 1'b0;
    logic [3:0]    sec_ones;
    logic [3:0]    sec_tens;
    logic [4*MD-1:0] mins;
    logic          running;
    logic          zero;
    logic          done;
    logic          load_err;
    logic [15:0]   count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    bcd_countdown_timer #(.MIN_DIGITS(MD), .TICK_DIV(TD)) dut (
        .clock           (clock),
        .clr             (clr),
        .load            (load),
        .preset_sec_ones (preset_sec_ones),
        .preset_sec_tens (preset_sec_tens),
        .preset_mins     (preset_mins),
        .start           (start),
        .stop            (stop),
        .reload_mode     (reload_mode),
        .sec_ones        (sec_ones),
        .sec_tens        (sec_tens),
        .mins            (mins),
        .running         (running),
        .zero            (zero),
        .done            (done),
        .load_err        (load_err)
    );

    assign count = {mins, sec_tens, sec_ones};

    // Clock generation.
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic sb_push(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input string tag);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty got=%0h", tag, count);
        end else begin
            check_eq(tag, 32'(count), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        {preset_mins, preset_sec_tens, preset_sec_ones} = v;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    // Watchdog: the run is a few hundred cycles; anything far beyond is a hang.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_done;
        int last_done;
        int done_cnt;
        bit run_dropped;

        // Reset state
        step(2);
        check_eq("rst_count", 32'(count), 32'h0000);
        check_eq("rst_zero", 32'(zero), 1);
        check_eq("rst_running", 32'(running), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_load_err", 32'(load_err), 0);
        clr = 1'b0;
        step(1);

        // Load 01:30, run down through the minute borrow
        sb_push(16'h0130);
        do_load(16'h0130);
        sb_check("s2_load");
        pulse_start();
        check_eq("s2_running", 32'(running), 1);
        step(3);
        check_eq("s2_before_tick", 32'(count), 32'h0130);
        sb_push(16'h0129);
        step(1);
        sb_check("s2_first_tick");
        sb_push(16'h0100);
        step(4 * 29);
        sb_check("s2_0100");
        sb_push(16'h0059);
        step(4);
        sb_check("s2_borrow");
        pulse_stop();

        // One-shot expiry
        reload_mode = 1'b0;
        do_load(16'h0002);
        pulse_start();
        sb_push(16'h0001);
        step(4);
        sb_check("s3_0001");
        step(3);
        check_eq("s3_done_early", 32'(done), 0);
        sb_push(16'h0000);
        step(1);
        sb_check("s3_0000");
        check_eq("s3_done", 32'(done), 1);
        check_eq("s3_stopped", 32'(running), 0);
        check_eq("s3_zero", 32'(zero), 1);
        step(1);
        check_eq("s3_done_width", 32'(done), 0);
        pulse_start();
        check_eq("s3_start_ignored", 32'(running), 0);
        step(4);
        check_eq("s3_held", 32'(count), 32'h0000);

        // Auto-reload
        reload_mode = 1'b1;
        do_load(16'h0002);
        pulse_start();
        sb_push(16'h0001);
        sb_push(16'h0000);
        sb_push(16'h0002);
        sb_push(16'h0001);
        sb_push(16'h0000);
        sb_push(16'h0002);
        first_done = -1;
        last_done = -1;
        done_cnt = 0;
        run_dropped = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            step(1);
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = i;
                last_done = i;
            end
            if (!running) run_dropped = 1'b1;
            if (i % 4 == 0) sb_check($sformatf("s4_seq_%0d", i));
        end
        check_eq("s4_done_count", 32'(done_cnt), 2);
        check_eq("s4_first_done", 32'(first_done), 8);
        check_eq("s4_done_period", 32'(last_done - first_done), 12);
        check_eq("s4_run_dropped", 32'(run_dropped), 0);
        pulse_stop();
        reload_mode = 1'b0;

        // Preset validation and clamping
        sb_push(16'h0059);
        do_load(16'h007C);
        sb_check("s5_clamp");
        check_eq("s5_err_set", 32'(load_err), 1);
        sb_push(16'h9059);
        do_load(16'hF059);
        sb_check("s5_min_clamp");
        check_eq("s5_err_min", 32'(load_err), 1);
        sb_push(16'h0010);
        do_load(16'h0010);
        sb_check("s5_valid");
        check_eq("s5_err_clear", 32'(load_err), 0);

        // Stop / start control
        do_load(16'h0041);
        pulse_start();
        sb_push(16'h0040);
        step(4);
        sb_check("s6_0040");
        pulse_stop();
        check_eq("s6_stopped", 32'(running), 0);
        sb_push(16'h0040);
        step(20);
        sb_check("s6_hold");
        start = 1'b1;
        stop = 1'b1;
        step(1);
        start = 1'b0;
        stop = 1'b0;
        check_eq("s6_stop_wins", 32'(running), 0);
        step(4);
        check_eq("s6_still_held", 32'(count), 32'h0040);
        pulse_start();
        sb_push(16'h0039);
        step(4);
        sb_check("s6_resume");
        check_eq("s6_running", 32'(running), 1);
        pulse_stop();

        // Asynchronous clear mid-run with load_err set
        do_load(16'h007C);
        check_eq("s1_err_pre", 32'(load_err), 1);
        pulse_start();
        step(6);
        #3;
        clr = 1'b1;
        #1;
        check_eq("s1_count", 32'(count), 32'h0000);
        check_eq("s1_zero", 32'(zero), 1);
        check_eq("s1_running", 32'(running), 0);
        check_eq("s1_done", 32'(done), 0);
        check_eq("s1_load_err", 32'(load_err), 0);
        step(1);
        clr = 1'b0;
        step(5);
        check_eq("s1_post_count", 32'(count), 32'h0000);
        check_eq("s1_post_running", 32'(running), 0);

        check_eq("sb_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
